// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter for the core data port (req/gnt/rvalid protocol).
// Requests lock until granted; responses are routed in order through an owner-ID FIFO.
module data_bus_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           m_req_i,
    input  logic [1:0]           m_we_i,
    input  logic [1:0][DW/8-1:0] m_be_i,
    input  logic [1:0][AW-1:0]   m_addr_i,
    input  logic [1:0][DW-1:0]   m_wdata_i,
    output logic [1:0]           m_gnt_o,
    output logic [1:0]           m_rvalid_o,
    output logic [DW-1:0]        m_rdata_o,
    output logic                 m_err_o,
    output logic                 data_req_o,
    output logic                 data_we_o,
    output logic [DW/8-1:0]      data_be_o,
    output logic [AW-1:0]        data_addr_o,
    output logic [DW-1:0]        data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [DW-1:0]        data_rdata_i,
    input  logic                 data_err_i,
    output logic                 protocol_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                       rr_prio;   // requester favoured when both request
    logic                       locked;
    logic                       lock_id;
    logic                       sel;
    logic [MAX_OUTSTANDING-1:0] owner;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       head_id;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sel = 1'b0;
        if (locked)
            sel = lock_id;
        else if (&m_req_i)
            sel = rr_prio;
        else if (m_req_i[1])
            sel = 1'b1;
    end

    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head_id    = owner[rd_ptr];

    // A full FIFO blocks the request even when a pop lands in the same cycle.
    assign data_req_o   = !rst_i & m_req_i[sel] & !fifo_full;
    assign data_we_o    = m_we_i[sel];
    assign data_be_o    = m_be_i[sel];
    assign data_addr_o  = m_addr_i[sel];
    assign data_wdata_o = m_wdata_i[sel];

    assign push = data_req_o & data_gnt_i;
    assign pop  = data_rvalid_i & !fifo_empty;

    assign m_rdata_o = data_rdata_i;
    assign m_err_o   = data_err_i;

    always_comb begin
        m_gnt_o              = '0;
        m_gnt_o[sel]         = push;
        m_rvalid_o           = '0;
        m_rvalid_o[head_id]  = pop & !rst_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_prio        <= 1'b0;
            locked         <= 1'b0;
            lock_id        <= 1'b0;
            owner          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (data_gnt_i) begin
                locked <= 1'b0;
            end else if (data_req_o) begin
                locked  <= 1'b1;
                lock_id <= sel;
            end

            if (push) begin
                rr_prio       <= ~sel;
                owner[wr_ptr] <= sel;
                wr_ptr        <= ptr_next(wr_ptr);
            end

            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            if (data_rvalid_i && fifo_empty)
                protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Two-requester arbiter for the core data memory port, using the req/gnt/rvalid protocol.
- Requester 0 is the load store unit; requester 1 is a secondary master (debug or DMA).
- Round-robin selection, request locking until grant, and in-order response routing via an owner-ID FIFO.
- Sits between the requesters and the single data bus towards memory/interconnect.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
m_req_i  input  2  per-requester request (bit n = requester n)
m_we_i  input  2  per-requester write enable
m_be_i  input  2x(DW/8)  per-requester byte enables
m_addr_i  input  2xAW  per-requester address
m_wdata_i  input  2xDW  per-requester write data
m_gnt_o  output  2  per-requester grant
m_rvalid_o  output  2  per-requester response valid
m_rdata_o  output  DW  response data, shared, qualified by m_rvalid_o
m_err_o  output  1  response error, shared, qualified by m_rvalid_o
data_req_o  output  1  downstream request
data_we_o  output  1  downstream write enable
data_be_o  output  DW/8  downstream byte enables
data_addr_o  output  AW  downstream address
data_wdata_o  output  DW  downstream write data
data_gnt_i  input  1  downstream grant
data_rvalid_i  input  1  downstream response valid
data_rdata_i  input  DW  downstream read data
data_err_i  input  1  downstream response error
protocol_err_o  output  1  sticky: data_rvalid_i seen with nothing outstanding

Behaviour:
- Reset (async, rst_i high):
  - FIFO empty; lock clear; priority pointer favours requester 0.
  - protocol_err_o=0.
  - All request/grant/rvalid outputs 0 while in reset.
- Selection:
  - If lock is set, sel = locked owner.
  - Otherwise sel = highest-priority requester with m_req_i set.
  - Ties are broken by the round-robin pointer.
- Downstream request:
  - data_req_o = m_req_i[sel] & !fifo_full.
  - data_we_o/be/addr/wdata are muxed from sel (combinational, zero latency).
- Grant:
  - m_gnt_o[sel] = data_gnt_i & data_req_o; the other bit is 0.
  - Same-cycle grant is allowed.
- Lock:
  - Set when data_req_o=1 and data_gnt_i=0; lock stores sel.
  - While locked, the other requester's request is ignored. Downstream req/we/be/addr/wdata therefore stay stable until grant (requesters hold inputs per protocol).
  - Cleared in the cycle data_gnt_i=1.
- Round-robin: on each handshake (data_req_o & data_gnt_i) by requester n, the pointer moves to favour requester 1-n.
- Owner FIFO:
  - Depth MAX_OUTSTANDING, stores the requester ID.
  - Push on handshake; pop on data_rvalid_i.
  - fifo_full blocks data_req_o even if a pop occurs in the same cycle (no bypass).
  - Simultaneous push and pop when not full: count unchanged, pointers both advance, wrap modulo depth.
- Response routing:
  - m_rvalid_o[head_id] = data_rvalid_i & !fifo_empty.
  - m_rdata_o = data_rdata_i and m_err_o = data_err_i, unconditionally.
  - Responses are strictly in order.
- Protocol error:
  - data_rvalid_i with FIFO empty: the response is dropped (no m_rvalid_o) and protocol_err_o sets until reset.
  - A pop concurrent with a push into an empty FIFO is not permitted; the response must come at least one cycle after grant.
- Reset mid-operation: outstanding IDs and lock are discarded. Late responses after reset raise protocol_err_o.

Test Plan:
- Both requesters assert at once after reset, data_gnt_i=1 -> requester 0 granted cycle 0, requester 1 cycle 1, then alternating.
- Req1 asserted (addr 0x100, we=1), data_gnt_i low 3 cycles, req0 rises in cycle 1 -> data_addr_o stays 0x100, data_we_o=1 for all 4 cycles; m_gnt_o=2'b10 in cycle 3 only.
- MAX_OUTSTANDING=2: two grants, no rvalid -> third request sees data_req_o=0. One rvalid -> data_req_o=1 the next cycle.
- Grant order req0 then req1; rvalids with rdata 0xAAAA then 0xBBBB -> m_rvalid_o=01 with 0xAAAA, then 10 with 0xBBBB.
- data_rvalid_i pulse with nothing outstanding -> m_rvalid_o=0, protocol_err_o=1 and held until rst_i.
- rst_i asserted with 2 outstanding, then a rvalid after release -> no m_rvalid_o, protocol_err_o=1; priority back to requester 0.
